// File: rtl/frame_max_pkg.sv
// Shared types and default sizing for the frame maximum tracker slice.
package frame_max_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int unsigned DEF_SIZE      = 8;
    localparam int unsigned DEF_FRAME_LEN = 16;

endpackage

// File: rtl/frame_max_tracker_comparator.sv
// Unsigned magnitude comparator reused by the tracker for each running extreme.
module frame_max_tracker_comparator
    import frame_max_pkg::*;
#(
    parameter int unsigned SIZE = DEF_SIZE
) (
    input  logic [SIZE-1:0] a_i,
    input  logic [SIZE-1:0] b_i,
    output logic            a_larger_o,
    output logic            equal_o
);

    assign a_larger_o = (a_i > b_i);
    assign equal_o    = (a_i == b_i);

endmodule

// File: rtl/frame_max_tracker.sv
// Per-frame maximum / first index / tie count over a valid-ready stream.
// Define FRAME_MAX_TRACKER_MIN_EN to also track the frame minimum and its first index.
module frame_max_tracker
    import frame_max_pkg::*;
#(
    parameter int unsigned SIZE      = DEF_SIZE,
    parameter int unsigned FRAME_LEN = DEF_FRAME_LEN,
    localparam int unsigned CNT_W    = $clog2(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SIZE-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SIZE-1:0]  max_data,
    output logic [CNT_W-1:0] max_index,
    output logic [CNT_W:0]   eq_count,
`ifdef FRAME_MAX_TRACKER_MIN_EN
    output logic [SIZE-1:0]  min_data,
    output logic [CNT_W-1:0] min_index,
`endif
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W:0]   EQ_ONE   = (CNT_W + 1)'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SIZE-1:0]  max_q,   max_d;
    logic [CNT_W-1:0] idx_q,   idx_d;
    logic [CNT_W:0]   eq_q,    eq_d;

    logic accept;
    logic last_sample;
    logic first_sample;
    logic in_gt_max;
    logic in_eq_max;

    assign in_ready     = (state_q == RUN);
    assign busy         = (state_q == RUN);
    assign out_valid    = (state_q == HOLD);
    assign accept       = in_valid && in_ready;
    assign last_sample  = (count_q == LAST_IDX);
    assign first_sample = (count_q == '0);

    frame_max_tracker_comparator #(
        .SIZE (SIZE)
    ) u_max_cmp (
        .a_i        (in_data),
        .b_i        (max_q),
        .a_larger_o (in_gt_max),
        .equal_o    (in_eq_max)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    count_d = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    // Counter parks on the last index instead of wrapping.
                    if (last_sample) begin
                        state_d = HOLD;
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (start) begin
                        state_d = RUN;
                        count_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_comb begin
        max_d = max_q;
        idx_d = idx_q;
        eq_d  = eq_q;
        if (accept) begin
            if (first_sample || in_gt_max) begin
                max_d = in_data;
                idx_d = count_q;
                eq_d  = EQ_ONE;
            end else if (in_eq_max) begin
                eq_d = eq_q + EQ_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_q <= '0;
            idx_q <= '0;
            eq_q  <= '0;
        end else begin
            max_q <= max_d;
            idx_q <= idx_d;
            eq_q  <= eq_d;
        end
    end

    assign max_data  = max_q;
    assign max_index = idx_q;
    assign eq_count  = eq_q;

`ifdef FRAME_MAX_TRACKER_MIN_EN
    logic [SIZE-1:0]  min_q,  min_d;
    logic [CNT_W-1:0] midx_q, midx_d;
    logic             min_gt_in;
    logic             min_eq_in;

    // Operands swapped so a_larger means the incoming sample is a new minimum.
    frame_max_tracker_comparator #(
        .SIZE (SIZE)
    ) u_min_cmp (
        .a_i        (min_q),
        .b_i        (in_data),
        .a_larger_o (min_gt_in),
        .equal_o    (min_eq_in)
    );

    always_comb begin
        min_d  = min_q;
        midx_d = midx_q;
        if (accept && (first_sample || min_gt_in)) begin
            min_d  = in_data;
            midx_d = count_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_q  <= '0;
            midx_q <= '0;
        end else begin
            min_q  <= min_d;
            midx_q <= midx_d;
        end
    end

    assign min_data  = min_q;
    assign min_index = midx_q;

    logic unused_min_eq;
    assign unused_min_eq = min_eq_in;
`endif

endmodule
